// File: rtl/game_sequencer.sv
// game_sequencer: Breakout play controller.
// Sequences serve / play / life-loss / end states, owns the brick map,
// tracks lives and a three-digit BCD score, and gates ball motion.
// Every output comes straight from a register.
module game_sequencer #(
    parameter int NUM_BRICKS   = 50,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic                  brick_hit,
    input  logic [5:0]            brick_idx,
    input  logic                  ball_lost,
    output logic [NUM_BRICKS-1:0] brick_state,
    output logic                  ball_run,
    output logic                  ball_reset,
    output logic [1:0]            lives,
    output logic [11:0]           score,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_LOST  = 3'd3,
        S_WIN   = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    localparam logic [NUM_BRICKS-1:0] ALL_BRICKS  = '1;
    localparam logic [1:0]            LIVES_INIT  = 2'(LIVES);
    localparam logic [7:0]            SERVE_LAST  = 8'(SERVE_FRAMES);
    localparam logic [6:0]            BRICK_COUNT = 7'(NUM_BRICKS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_start_d;
    logic [7:0]              r_serve_cnt;
    logic                    r_ball_run;
    logic                    r_ball_reset;
    logic [NUM_BRICKS-1:0]   r_brick_state;
    logic [1:0]              r_lives;
    logic [11:0]             r_score;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    state_t                  w_next_state;
    logic                    w_start_rise;
    logic [7:0]              w_serve_cnt_inc;
    logic                    w_serve_done;
    logic [63:0]             w_bricks_wide;
    logic [63:0]             w_hit_mask_wide;
    logic [NUM_BRICKS-1:0]   w_hit_mask;
    logic [NUM_BRICKS-1:0]   w_bricks_after;
    logic                    w_idx_in_range;
    logic                    w_hit_accept;
    logic                    w_last_cleared;
    logic                    w_new_game;
    logic                    w_enter_serve;

    // Saturating BCD increment of a three-digit score (999 holds).
    function automatic logic [11:0] bcd_inc(input logic [11:0] value);
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] unit;
        hund = value[11:8];
        tens = value[7:4];
        unit = value[3:0];
        if (value == 12'h999) begin
            return value;
        end
        if (unit == 4'd9) begin
            unit = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
                hund = hund + 4'd1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            unit = unit + 4'd1;
        end
        return {hund, tens, unit};
    endfunction

    // A button already held when reset releases must not count as a press,
    // which is why r_start_d comes out of reset at 1.
    assign w_start_rise    = start & ~r_start_d;

    assign w_serve_cnt_inc = r_serve_cnt + 8'd1;
    assign w_serve_done    = (r_state == S_SERVE) && frame_tick &&
                             (w_serve_cnt_inc == SERVE_LAST);

    // Widen the map to the full 6-bit index space so any brick_idx can be
    // looked up; indices at or above NUM_BRICKS read as zero.
    assign w_bricks_wide   = 64'(r_brick_state);
    assign w_hit_mask_wide = 64'd1 << brick_idx;
    assign w_hit_mask      = w_hit_mask_wide[NUM_BRICKS-1:0];
    assign w_bricks_after  = r_brick_state & ~w_hit_mask;
    assign w_idx_in_range  = ({1'b0, brick_idx} < BRICK_COUNT);

    assign w_hit_accept    = (r_state == S_PLAY) && brick_hit &&
                             w_idx_in_range && w_bricks_wide[brick_idx];
    assign w_last_cleared  = w_hit_accept && (w_bricks_after == '0);

    assign w_new_game      = w_start_rise &&
                             ((r_state == S_WIN) || (r_state == S_OVER));
    assign w_enter_serve   = (w_next_state == S_SERVE) && (r_state != S_SERVE);

    // Next-state decode; unused codes fall back to IDLE.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_next_state = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_serve_done) begin
                    w_next_state = S_PLAY;
                end
            end
            S_PLAY: begin
                // The hit is resolved first: clearing the last brick beats
                // a simultaneous ball loss.
                if (w_last_cleared) begin
                    w_next_state = S_WIN;
                end else if (ball_lost) begin
                    w_next_state = S_LOST;
                end
            end
            S_LOST: begin
                if (r_lives <= 2'd1) begin
                    w_next_state = S_OVER;
                end else begin
                    w_next_state = S_SERVE;
                end
            end
            S_WIN, S_OVER: begin
                if (w_start_rise) begin
                    w_next_state = S_SERVE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register and start-button edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            r_state   <= w_next_state;
            r_start_d <= start;
        end
    end

    // Serve hold counter: cleared on SERVE entry, counts frames while serving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_serve_cnt <= 8'd0;
        end else if (w_enter_serve) begin
            r_serve_cnt <= 8'd0;
        end else if ((r_state == S_SERVE) && frame_tick) begin
            r_serve_cnt <= w_serve_cnt_inc;
        end
    end

    // Ball control: run only in PLAY, pulse reset on the first SERVE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ball_run   <= 1'b0;
            r_ball_reset <= 1'b0;
        end else begin
            r_ball_run   <= (w_next_state == S_PLAY);
            r_ball_reset <= w_enter_serve;
        end
    end

    // Brick map: refilled on a new game, one bit cleared per accepted hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the map is a plain flop vector, so it can and must reset to all bricks present.
            r_brick_state <= ALL_BRICKS;
        end else if (w_new_game) begin
            r_brick_state <= ALL_BRICKS;
        end else if (w_hit_accept) begin
            r_brick_state <= w_bricks_after;
        end
    end

    // Score: cleared on a new game, BCD increment per accepted hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_score <= 12'h000;
        end else if (w_new_game) begin
            r_score <= 12'h000;
        end else if (w_hit_accept) begin
            r_score <= bcd_inc(r_score);
        end
    end

    // Lives: reloaded on a new game, decremented during the LOST cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lives <= LIVES_INIT;
        end else if (w_new_game) begin
            r_lives <= LIVES_INIT;
        end else if ((r_state == S_LOST) && (r_lives != 2'd0)) begin
            r_lives <= r_lives - 2'd1;
        end
    end

    assign brick_state = r_brick_state;
    assign ball_run    = r_ball_run;
    assign ball_reset  = r_ball_reset;
    assign lives       = r_lives;
    assign score       = r_score;
    assign state       = r_state;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level play controller for the Breakout design. It sequences a game through serve, play, life-loss and end states, and owns the 50-bit brick map consumed by pixel_maker. It also tracks lives and a BCD score, and gates ball_logic motion. It sits between the collision/paddle/ball datapath and the renderer, clocked on CLOCK_50.

## Interface
- NUM_BRICKS, 50: width of brick map; legal 1..64.
- LIVES, 3: lives loaded at reset and new game; legal 1..3.
- SERVE_FRAMES, 60: frame ticks the ball is held before launch; legal 1..255.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame, already synchronized to clk.
- start  in  1  debounced launch/restart level, active high.
- brick_hit  in  1  one-cycle pulse from collision logic.
- brick_idx  in  6  index of the brick hit; valid only with brick_hit.
- ball_lost  in  1  one-cycle pulse; ball passed below paddle.
- brick_state  out  NUM_BRICKS  1 = brick present.
- ball_run  out  1  ball_logic advances only while high.
- ball_reset  out  1  one-cycle pulse; ball_logic reloads the serve position.
- lives  out  2  remaining lives.
- score  out  12  three BCD digits, [11:8] hundreds.
- state  out  3  current FSM state code.

## Operation
- FSM states: IDLE=0, SERVE=1, PLAY=2, LOST=3, WIN=4, OVER=5. Codes 6 and 7 are unused and recover to IDLE on the next clk.
- Start edge: start_d register; start_rise = start & ~start_d. start_d resets to 1, so a button held through reset does not launch.
- IDLE: ball_run=0. On start_rise, go to SERVE.
- SERVE:
  - On entry, pulse ball_reset and clear serve_cnt (8 bits).
  - Each frame_tick increments serve_cnt.
  - The frame_tick that brings serve_cnt to SERVE_FRAMES moves the FSM to PLAY.
  - ball_run=0. brick_hit and ball_lost are ignored.
- PLAY: ball_run=1.
  - A brick_hit is accepted only if brick_idx < NUM_BRICKS and the addressed bit is 1. Accepting it clears the bit and increments score by 1 in BCD.
  - Score saturates at 999.
  - A hit on an already-cleared brick or an out-of-range index is a no-op, with no score change.
  - If an accepted hit clears the last set bit, go to WIN.
  - Otherwise, ball_lost moves the FSM to LOST.
- Simultaneous brick_hit and ball_lost in PLAY: the hit is processed first. If it clears the last brick, WIN wins and the loss is discarded. Otherwise, score updates and the FSM goes to LOST.
- LOST: single-cycle state; lives decrements by 1. If lives was 1, go to OVER (lives=0); otherwise go to SERVE.
- WIN, OVER: ball_run=0; brick_state, score and lives hold. On start_rise, reload brick_state to all ones, lives=LIVES and score=0, then go to SERVE.
- BCD increment rules:
  - A units digit of 9 wraps to 0 with carry into tens.
  - A tens digit of 9 with carry wraps to 0 with carry into hundreds.
  - At 999, hold.
- A start_rise during SERVE, PLAY or LOST is ignored.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Reset values (async on rst=0): state=IDLE, brick_state all ones, lives=LIVES, score=0, ball_run=0, ball_reset=0, serve_cnt=0.
- brick_hit sampled at edge N: brick_state and score update at N+1. The WIN state is also visible at N+1, and ball_run falls at N+1.
- ball_lost at edge N: state=LOST at N+1 with ball_run=0, and lives decremented at N+2, with state=SERVE or OVER.
- ball_reset is high for exactly the first cycle in SERVE.
- Launch timing: ball_run rises the cycle after the SERVE_FRAMES-th frame_tick counted in SERVE.
- rst asserted mid-game forces reset values immediately. Release is synchronous to the next clk edge.

## Test plan
- Launch: reset, start held high through release → stays IDLE. Then drop start and raise it → SERVE with one ball_reset pulse. After 60 frame_ticks, ball_run=1 on the following cycle.
- Bricks: in PLAY, hit idx 5 twice, then idx 50 and idx 63 → bit 5 cleared, score=001, other hits no-op.
- BCD: 10 accepted hits → score=0x010. With NUM_BRICKS=50, clearing all bricks → score=0x050 and state=WIN, lives unchanged.
- Simultaneous: with one brick left, brick_hit on it and ball_lost in the same cycle → WIN, lives unchanged. Repeat with two bricks left → LOST, score +1, lives-1.
- Lives: three ball_lost events, each followed by a full serve → lives 2, 1, 0. The third goes to OVER with ball_run=0. start_rise → lives=3, score=0, all bricks set, SERVE.
- Reset mid-PLAY with bricks cleared and score 0x023 → all outputs take reset values asynchronously, before the next clk edge.
